phy_tx_sched: RTL and testbench

PHY_TX_SCHED -- requirements
Module: phy_tx_sched

---
 rtl/phy_tx_pkg.sv | 15 +
 rtl/phy_rr_arb.sv | 29 ++
 rtl/phy_tx_sched.sv | 127 ++++++++++++
 tb/tb_phy_tx_sched.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/phy_tx_pkg.sv
// Shared types and constants for the PHY transmit scheduler.
package phy_tx_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_SYNC     = 2'd1,
    ST_RUN      = 2'd2
  } state_e;

  localparam logic [7:0]  IDLE_SYMBOL_DEF = 8'hBC;
  localparam int unsigned DATA_W          = 8;
  localparam int unsigned BURST_W         = 4;
  localparam int unsigned SYNC_W          = 8;

endpackage

// File: rtl/phy_rr_arb.sv
// Two-requester round-robin arbiter with a burst allowance for the current owner.
module phy_rr_arb
  import phy_tx_pkg::*;
#(
  parameter int unsigned MAX_BURST = 2
) (
  input  logic [1:0]         valid_i,
  input  logic               last_i,
  input  logic [BURST_W-1:0] burst_i,
  output logic [1:0]         grant_o
);

  logic keep_c;
  logic winner_c;

  // Owner keeps the lane only while it has an unfinished burst; otherwise the other side wins.
  always_comb begin
    keep_c   = (burst_i != '0) && (burst_i < BURST_W'(MAX_BURST));
    winner_c = keep_c ? last_i : ~last_i;
    grant_o  = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = winner_c ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/phy_tx_sched.sv
// Link scheduler: sync preamble after enable, then arbitrates two byte requesters onto one lane.
module phy_tx_sched
  import phy_tx_pkg::*;
#(
  parameter int unsigned SYNC_COUNT  = 4,
  parameter int unsigned MAX_BURST   = 2,
  parameter logic [7:0]  IDLE_SYMBOL = IDLE_SYMBOL_DEF
) (
  input  logic              clk_f,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] data_in_0,
  input  logic              valid_in_0,
  output logic              ready_0,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic              valid_in_1,
  output logic              ready_1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              sel_out,
  output logic              active_out
);

  state_e              state_q;
  logic [SYNC_W-1:0]   sync_cnt_q;
  logic [BURST_W-1:0]  burst_q;
  logic                last_q;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q;
  logic                sel_q;
  logic                active_q;

  logic [1:0]          grant_c;
  logic                run_en_c;
  logic                xfer_c;
  logic                xfer_sel_c;

  phy_rr_arb #(
    .MAX_BURST (MAX_BURST)
  ) u_arb (
    .valid_i ({valid_in_1, valid_in_0}),
    .last_i  (last_q),
    .burst_i (burst_q),
    .grant_o (grant_c)
  );

  // Accepts only in RUN with enable still high; arbiter grants imply the matching valid.
  assign run_en_c   = (state_q == ST_RUN) && enable;
  assign ready_0    = run_en_c && grant_c[0];
  assign ready_1    = run_en_c && grant_c[1];
  assign xfer_c     = ready_0 || ready_1;
  assign xfer_sel_c = ready_1;

  // State and registered lane outputs; output registers track the state being entered.
  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_DISABLED;
      sync_cnt_q <= '0;
      burst_q    <= '0;
      last_q     <= 1'b1;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sel_q      <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      sel_q   <= 1'b0;
      if (!enable) begin
        state_q    <= ST_DISABLED;
        sync_cnt_q <= '0;
        burst_q    <= '0;
        last_q     <= 1'b1;
        data_q     <= '0;
        active_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_DISABLED: begin
            state_q    <= ST_SYNC;
            sync_cnt_q <= '0;
            burst_q    <= '0;
            last_q     <= 1'b1;
            data_q     <= IDLE_SYMBOL;
            active_q   <= 1'b0;
          end
          ST_SYNC: begin
            data_q <= IDLE_SYMBOL;
            if (sync_cnt_q == SYNC_W'(SYNC_COUNT - 1)) begin
              state_q  <= ST_RUN;
              active_q <= 1'b1;
            end else begin
              sync_cnt_q <= sync_cnt_q + SYNC_W'(1);
            end
          end
          ST_RUN: begin
            active_q <= 1'b1;
            if (xfer_c) begin
              data_q  <= xfer_sel_c ? data_in_1 : data_in_0;
              valid_q <= 1'b1;
              sel_q   <= xfer_sel_c;
              last_q  <= xfer_sel_c;
              if ((xfer_sel_c == last_q) && (burst_q != '0)) begin
                burst_q <= (burst_q >= BURST_W'(MAX_BURST)) ? BURST_W'(MAX_BURST)
                                                             : burst_q + BURST_W'(1);
              end else begin
                burst_q <= BURST_W'(1);
              end
            end else begin
              data_q  <= IDLE_SYMBOL;
              burst_q <= '0;
            end
          end
          default: begin
            state_q  <= ST_DISABLED;
            data_q   <= '0;
            active_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign sel_out    = sel_q;
  assign active_out = active_q;

endmodule

// File: tb/tb_phy_tx_sched.sv
// Bench for phy_tx_sched: directed vector table, async reset checks, randomized run vs reference model.
module tb_phy_tx_sched;

  localparam int SC = 4;
  localparam int MB = 2;
  localparam logic [7:0] IDLE = 8'hBC;

  logic       clk_f = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] data_in_0 = 8'h00;
  logic       valid_in_0 = 1'b0;
  logic       ready_0;
  logic [7:0] data_in_1 = 8'h00;
  logic       valid_in_1 = 1'b0;
  logic       ready_1;
  logic [7:0] data_out;
  logic       valid_out;
  logic       sel_out;
  logic       active_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_f = ~clk_f;

  phy_tx_sched #(.SYNC_COUNT(SC), .MAX_BURST(MB), .IDLE_SYMBOL(IDLE)) dut (
    .clk_f      (clk_f),
    .reset      (reset),
    .enable     (enable),
    .data_in_0  (data_in_0),
    .valid_in_0 (valid_in_0),
    .ready_0    (ready_0),
    .data_in_1  (data_in_1),
    .valid_in_1 (valid_in_1),
    .ready_1    (ready_1),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .sel_out    (sel_out),
    .active_out (active_out)
  );

  typedef struct {
    logic       en;
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       r0;
    logic       r1;
    logic [7:0] dout;
    logic       vout;
    logic       sel;
    logic       act;
  } vec_t;

  vec_t tbl[$];

  // Reference model: enabled-cycle count decides the phase, owner/run-length decide arbitration.
  int         m_en_run;
  int         m_last;
  int         m_len;
  logic [7:0] e_data;
  logic       e_valid;
  logic       e_sel;
  logic       e_act;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic en, input logic v0, input logic [7:0] d0,
                     input logic v1, input logic [7:0] d1, input logic r0, input logic r1,
                     input logic [7:0] dout, input logic vout, input logic sel, input logic act);
    vec_t v;
    v.en = en; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.dout = dout; v.vout = vout; v.sel = sel; v.act = act;
    tbl.push_back(v);
  endtask

  task automatic apply(input logic en, input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1);
    enable = en; valid_in_0 = v0; data_in_0 = d0; valid_in_1 = v1; data_in_1 = d1;
  endtask

  task automatic model_reset();
    m_en_run = 0; m_last = 1; m_len = 0;
    e_data = 8'h00; e_valid = 1'b0; e_sel = 1'b0; e_act = 1'b0;
  endtask

  function automatic int model_grant(input logic en, input logic v0, input logic v1);
    if (!en || m_en_run <= SC) return -1;
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
    if (v0 && v1) begin
      if (m_len >= 1 && m_len < MB) return m_last;
      return 1 - m_last;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic en, input logic v0, input logic [7:0] d0,
                            input logic v1, input logic [7:0] d1);
    int g;
    g = model_grant(en, v0, v1);
    e_valid = 1'b0;
    e_sel   = 1'b0;
    if (!en) begin
      m_en_run = 0; m_last = 1; m_len = 0;
      e_data = 8'h00; e_act = 1'b0;
    end else if (m_en_run <= SC) begin
      m_en_run++;
      m_last = 1; m_len = 0;
      e_data = IDLE;
      e_act  = (m_en_run > SC);
    end else begin
      e_act = 1'b1;
      if (g >= 0) begin
        e_data  = (g == 1) ? d1 : d0;
        e_valid = 1'b1;
        e_sel   = (g == 1);
        if (g == m_last && m_len > 0) m_len = (m_len < MB) ? m_len + 1 : MB;
        else m_len = 1;
        m_last = g;
      end else begin
        e_data = IDLE;
        m_len  = 0;
      end
    end
  endtask

  task automatic chk_outs(input string tag, input logic [7:0] d, input logic v,
                          input logic s, input logic a);
    chk({tag, ".data_out"},   data_out,   d);
    chk({tag, ".valid_out"},  valid_out,  8'(v));
    chk({tag, ".sel_out"},    sel_out,    8'(s));
    chk({tag, ".active_out"}, active_out, 8'(a));
  endtask

  initial begin
    // Sync preamble, tie to requester 0, burst rotation, idle lane, single requester, drop/re-enable.
    for (int i = 0; i < 4; i++) add(1, 0, 8'h00, 0, 8'h00, 0, 0, IDLE, 0, 0, 0);
    add(1, 0, 8'h00, 0, 8'h00, 0, 0, IDLE,  0, 0, 1);
    add(1, 1, 8'h10, 1, 8'h20, 1, 0, 8'h10, 1, 0, 1);
    add(1, 1, 8'h11, 1, 8'h20, 1, 0, 8'h11, 1, 0, 1);
    add(1, 1, 8'h12, 1, 8'h20, 0, 1, 8'h20, 1, 1, 1);
    add(1, 1, 8'h12, 1, 8'h21, 0, 1, 8'h21, 1, 1, 1);
    add(1, 1, 8'h12, 1, 8'h22, 1, 0, 8'h12, 1, 0, 1);
    add(1, 1, 8'h13, 1, 8'h22, 1, 0, 8'h13, 1, 0, 1);
    add(1, 0, 8'h00, 0, 8'h00, 0, 0, IDLE,  0, 0, 1);
    add(1, 1, 8'hA1, 0, 8'h00, 1, 0, 8'hA1, 1, 0, 1);
    add(1, 1, 8'hA2, 0, 8'h00, 1, 0, 8'hA2, 1, 0, 1);
    add(1, 1, 8'hA3, 0, 8'h00, 1, 0, 8'hA3, 1, 0, 1);
    add(1, 0, 8'h00, 1, 8'h5A, 0, 1, 8'h5A, 1, 1, 1);
    add(0, 1, 8'h77, 1, 8'h5B, 0, 0, 8'h00, 0, 0, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 0, 8'h00, 0, 8'h00, 0, 0, IDLE, 0, 0, 0);
    add(1, 0, 8'h00, 0, 8'h00, 0, 0, IDLE,  0, 0, 1);
    add(1, 1, 8'h30, 1, 8'h40, 1, 0, 8'h30, 1, 0, 1);

    reset  = 1'b0;
    enable = 1'b1;
    #12;
    chk_outs("reset", 8'h00, 0, 0, 0);
    chk("reset.ready_0", ready_0, 8'h00);
    @(negedge clk_f);
    reset = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i].en, tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1);
      #2;
      chk($sformatf("t%0d.ready_0", i), ready_0, 8'(tbl[i].r0));
      chk($sformatf("t%0d.ready_1", i), ready_1, 8'(tbl[i].r1));
      @(posedge clk_f);
      #1;
      chk_outs($sformatf("t%0d", i), tbl[i].dout, tbl[i].vout, tbl[i].sel, tbl[i].act);
    end

    // Asynchronous reset in the middle of a RUN cycle with both requesters pending.
    apply(1, 1, 8'h31, 1, 8'h41);
    #2;
    reset = 1'b0;
    #1;
    chk_outs("async_rst", 8'h00, 0, 0, 0);
    chk("async_rst.ready_0", ready_0, 8'h00);
    chk("async_rst.ready_1", ready_1, 8'h00);
    @(negedge clk_f);
    reset = 1'b1;
    model_reset();

    for (int n = 0; n < 3000; n++) begin
      logic       en, v0, v1;
      logic [7:0] d0, d1;
      int         g;
      if (n % 500 == 499) begin
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk_outs("rnd_rst", e_data, e_valid, e_sel, e_act);
        @(negedge clk_f);
        reset = 1'b1;
      end
      en = ($urandom_range(0, 99) < 96);
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      d0 = 8'($urandom_range(0, 255));
      d1 = 8'($urandom_range(0, 255));
      apply(en, v0, d0, v1, d1);
      #2;
      g = model_grant(en, v0, v1);
      chk("rnd.ready_0", ready_0, 8'(g == 0));
      chk("rnd.ready_1", ready_1, 8'(g == 1));
      @(posedge clk_f);
      model_edge(en, v0, d0, v1, d1);
      #1;
      chk_outs("rnd", e_data, e_valid, e_sel, e_act);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
